line_clear_ctrl: RTL and testbench

//  Sequences line clearing on the playfield store (PLAYFIELD_ROWS x PLAYFIELD_COLS of tile_type_t).
//  On start it scans rows bottom-up and detects full rows (no BLANK tile).
//  It compacts surviving rows downward in a single pass, back-fills vacated top rows with BLANK, and reports the count.

---
 rtl/line_clear_ctrl_pkg.sv | 9 +
 rtl/line_clear_ctrl_row_full_detect.sv | 14 +
 rtl/line_clear_ctrl.sv | 72 +++++++
 tb/tb_line_clear_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// line_clear_ctrl_pkg: playfield tile/row types and line-clear FSM states
package line_clear_ctrl_pkg;
  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;
  typedef enum logic [2:0] {BLANK, TILE_I, TILE_O, TILE_T, TILE_S, TILE_Z, TILE_J, TILE_L} tile_type_t;
  typedef tile_type_t [PLAYFIELD_COLS-1:0] tile_row_t;
  typedef enum logic [2:0] {IDLE, RD, EVAL, FILL, DONE} lc_state_t;
  localparam tile_row_t BLANK_ROW = '{default: BLANK};
endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// row_full_detect: flags a row whose every tile is non-BLANK
module row_full_detect
  import line_clear_ctrl_pkg::*;
#(
  parameter int COLS = PLAYFIELD_COLS
) (
  input  logic [COLS*3-1:0] row,
  output logic              full
);
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < COLS; i++) full &= row[i*3 +: 3] != 3'(BLANK);
  end
endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: bottom-up full-row removal with single-pass compaction and top back-fill
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int ROWS = PLAYFIELD_ROWS,
  parameter int COLS = PLAYFIELD_COLS,
  localparam int ROW_W = $clog2(ROWS),
  localparam int CNT_W = $clog2(ROWS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  lines_cleared,
  output logic [ROW_W-1:0]  rd_row,
  input  logic [COLS*3-1:0] rd_data,
  output logic              wr_en,
  output logic [ROW_W-1:0]  wr_row,
  output logic [COLS*3-1:0] wr_data
);
  lc_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             full;
  row_full_detect #(.COLS(COLS)) u_full (.row(rd_data), .full(full));
  assign cnt_next = cnt + CNT_W'(full);
  assign done     = state == DONE;
  assign wr_en    = state == FILL || (state == EVAL && !full && wr_row != rd_row);
  assign wr_data  = state == EVAL ? rd_data : '0;
  // rd_row doubles as the read pointer and is loaded a cycle early so RAM data lands in EVAL;
  // wr_row doubles as the write pointer and ends the copy phase at cnt-1, the first row to blank
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      lines_cleared <= '0;
      rd_row        <= '0;
      wr_row        <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state         <= RD;
          busy          <= 1'b1;
          rd_row        <= ROW_W'(ROWS - 1);
          wr_row        <= ROW_W'(ROWS - 1);
          cnt           <= '0;
          lines_cleared <= '0;
        end
        RD: state <= EVAL;
        EVAL: begin
          cnt <= cnt_next;
          if (!full && wr_row != '0) wr_row <= wr_row - 1'b1;
          if (rd_row == '0) begin
            lines_cleared <= cnt_next;
            state         <= cnt_next != '0 ? FILL : DONE;
          end else begin
            rd_row <= rd_row - 1'b1;
            state  <= RD;
          end
        end
        FILL: if (wr_row == '0) state <= DONE; else wr_row <= wr_row - 1'b1;
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: directed scenarios against a behavioural playfield RAM
module tb_line_clear_ctrl;
  localparam int R = 20;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        busy, done, wr_en;
  logic [4:0]  lines_cleared, rd_row, wr_row;
  logic [29:0] rd_data, wr_data;
  logic [29:0] mem [R];
  logic [29:0] fld [R];
  logic [29:0] exp_row [R];
  logic        ld = 1'b0;
  logic [4:0]  ld_row = '0;
  logic [29:0] ld_data = '0;
  int nwr = 0, checks = 0, errors = 0;
  int dcyc, n0;
  bit b_done, b_after;

  line_clear_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .rd_row(rd_row), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) mem[ld_row] <= ld_data;
    else if (wr_en) begin
      mem[wr_row] <= wr_data;
      nwr <= nwr + 1;
    end
    rd_data <= mem[rd_row];
  end

  function automatic logic [29:0] pat(input int r);
    logic [29:0] v = '0;
    v[2:0] = 3'((r % 7) + 1);
    v[5:3] = 3'((r / 7) + 1);
    return v;
  endfunction

  function automatic logic [29:0] full_row(input int k);
    logic [29:0] v = '0;
    for (int c = 0; c < 10; c++) v[c*3 +: 3] = 3'((k % 7) + 1);
    return v;
  endfunction

  task automatic load_field;
    for (int r = 0; r < R; r++) begin
      @(negedge clk);
      ld = 1'b1; ld_row = 5'(r); ld_data = fld[r];
    end
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run_pass(input int poke, input bit poke_done, output int dc, output bit bd, output bit ba);
    dc = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t < 150; t++) begin
      if (done) begin dc = t; break; end
      start = t == poke;
      @(posedge clk); #1;
    end
    bd = busy;
    start = poke_done;
    @(posedge clk); #1;
    start = 1'b0;
    ba = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, wr_en} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, wr_en}); end
    checks++;
    if ({lines_cleared, rd_row, wr_row} !== 15'd0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {lines_cleared, rd_row, wr_row}); end
    checks++;
    if (wr_data !== 30'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_empty;
    for (int r = 0; r < R; r++) fld[r] = '0;
    load_field();
    n0 = nwr;
    run_pass(0, 0, dcyc, b_done, b_after);
    checks++; if (dcyc !== 41) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 41", dcyc); end
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL empty_lines: got %0d expected 0", lines_cleared); end
    checks++; if (nwr - n0 !== 0) begin errors++; $display("FAIL empty_writes: got %0d expected 0", nwr - n0); end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL empty_busy_done: got %b expected 1", b_done); end
    checks++; if (b_after !== 1'b0) begin errors++; $display("FAIL empty_busy_after: got %b expected 0", b_after); end
  endtask

  task automatic test_single;
    for (int r = 0; r < 18; r++) fld[r] = pat(r);
    fld[18] = 30'd3;
    fld[19] = full_row(1);
    for (int r = 1; r < R; r++) exp_row[r] = fld[r-1];
    exp_row[0] = '0;
    load_field();
    n0 = nwr;
    run_pass(0, 0, dcyc, b_done, b_after);
    checks++; if (dcyc !== 42) begin errors++; $display("FAIL single_done_cycle: got %0d expected 42", dcyc); end
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL single_lines: got %0d expected 1", lines_cleared); end
    checks++; if (nwr - n0 !== 20) begin errors++; $display("FAIL single_writes: got %0d expected 20", nwr - n0); end
    for (int r = 0; r < R; r++) begin
      checks++;
      if (mem[r] !== exp_row[r]) begin errors++; $display("FAIL single_row%0d: got %h expected %h", r, mem[r], exp_row[r]); end
    end
  endtask

  task automatic test_four;
    for (int r = 0; r < R; r++) fld[r] = (r == 19 || r == 17 || r == 15 || r == 13) ? full_row(r) : pat(r);
    exp_row[19] = pat(18); exp_row[18] = pat(16); exp_row[17] = pat(14); exp_row[16] = pat(12);
    for (int r = 4; r < 16; r++) exp_row[r] = pat(r - 4);
    for (int r = 0; r < 4; r++) exp_row[r] = '0;
    load_field();
    n0 = nwr;
    run_pass(0, 0, dcyc, b_done, b_after);
    checks++; if (dcyc !== 45) begin errors++; $display("FAIL four_done_cycle: got %0d expected 45", dcyc); end
    checks++; if (lines_cleared !== 5'd4) begin errors++; $display("FAIL four_lines: got %0d expected 4", lines_cleared); end
    checks++; if (nwr - n0 !== 20) begin errors++; $display("FAIL four_writes: got %0d expected 20", nwr - n0); end
    for (int r = 0; r < R; r++) begin
      checks++;
      if (mem[r] !== exp_row[r]) begin errors++; $display("FAIL four_row%0d: got %h expected %h", r, mem[r], exp_row[r]); end
    end
  endtask

  task automatic test_boundary_row;
    for (int r = 0; r < R; r++) fld[r] = '0;
    fld[19] = full_row(2);
    fld[19][29:27] = 3'd0;
    load_field();
    n0 = nwr;
    run_pass(0, 0, dcyc, b_done, b_after);
    checks++; if (lines_cleared !== 5'd0) begin errors++; $display("FAIL nine_lines: got %0d expected 0", lines_cleared); end
    checks++; if (mem[19] !== fld[19]) begin errors++; $display("FAIL nine_row19: got %h expected %h", mem[19], fld[19]); end
    checks++; if (nwr - n0 !== 0) begin errors++; $display("FAIL nine_writes: got %0d expected 0", nwr - n0); end
    fld[19] = full_row(2);
    load_field();
    run_pass(0, 0, dcyc, b_done, b_after);
    checks++; if (dcyc !== 42) begin errors++; $display("FAIL ten_done_cycle: got %0d expected 42", dcyc); end
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL ten_lines: got %0d expected 1", lines_cleared); end
    checks++; if (mem[19] !== 30'd0) begin errors++; $display("FAIL ten_row19: got %h expected 0", mem[19]); end
  endtask

  task automatic test_all_full;
    for (int r = 0; r < R; r++) fld[r] = full_row(r);
    load_field();
    n0 = nwr;
    run_pass(0, 0, dcyc, b_done, b_after);
    checks++; if (dcyc !== 61) begin errors++; $display("FAIL full_done_cycle: got %0d expected 61", dcyc); end
    checks++; if (lines_cleared !== 5'd20) begin errors++; $display("FAIL full_lines: got %0d expected 20", lines_cleared); end
    checks++; if (nwr - n0 !== 20) begin errors++; $display("FAIL full_writes: got %0d expected 20", nwr - n0); end
    for (int r = 0; r < R; r++) begin
      checks++;
      if (mem[r] !== 30'd0) begin errors++; $display("FAIL full_row%0d: got %h expected 0", r, mem[r]); end
    end
  endtask

  task automatic test_start_ignored;
    for (int r = 0; r < 18; r++) fld[r] = pat(r);
    fld[18] = 30'd3;
    fld[19] = full_row(1);
    load_field();
    run_pass(10, 1, dcyc, b_done, b_after);
    checks++; if (dcyc !== 42) begin errors++; $display("FAIL ign_done_cycle: got %0d expected 42", dcyc); end
    checks++; if (lines_cleared !== 5'd1) begin errors++; $display("FAIL ign_lines: got %0d expected 1", lines_cleared); end
    checks++; if (b_after !== 1'b0) begin errors++; $display("FAIL ign_busy_after: got %b expected 0", b_after); end
    checks++; if (mem[19] !== 30'd3) begin errors++; $display("FAIL ign_row19: got %h expected 3", mem[19]); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ign_idle%0d: got %b expected 00", i, {busy, done}); end
    end
  endtask

  task automatic test_reset_in_fill;
    for (int r = 0; r < R; r++) fld[r] = (r == 19 || r == 17 || r == 15 || r == 13) ? full_row(r) : pat(r);
    load_field();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, wr_row, wr_data} !== {1'b1, 5'd2, 30'd0}) begin errors++; $display("FAIL fill_write: got %b/%0d/%h expected 1/2/0", wr_en, wr_row, wr_data); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, wr_en, done, lines_cleared} !== 8'd0) begin errors++; $display("FAIL abort_outputs: got %b expected 0", {busy, wr_en, done, lines_cleared}); end
    n0 = nwr;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (nwr - n0 !== 0) begin errors++; $display("FAIL abort_writes: got %0d expected 0", nwr - n0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_four();
    test_boundary_row();
    test_all_full();
    test_start_ignored();
    test_reset_in_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
